// File: rtl/alu_op_sequencer_if.sv
// Request and result handshake bundle for alu_op_sequencer.
// The master side issues ops and consumes results; the sequencer is the slave.
interface alu_op_sequencer_if #(
    parameter int m = 4,
    parameter int n = 2
);
    logic         req_valid;
    logic         req_ready;
    logic [n-1:0] op;
    logic [m-1:0] argA;
    logic [m-1:0] argB;
    logic [m-1:0] result;
    logic [1:0]   status;
    logic         valid;
    logic         ready;

    modport master (
        output req_valid, op, argA, argB, ready,
        input  req_ready, result, status, valid
    );

    modport slave (
        input  req_valid, op, argA, argB, ready,
        output req_ready, result, status, valid
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Control stage feeding the combinational arithmetic units: latches one
// request, holds operands for a settle window, captures the chosen unit.
module alu_op_sequencer #(
    parameter int m      = 4,
    parameter int n      = 2,
    parameter int SETTLE = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    alu_op_sequencer_if.slave   io_bus,
    output logic [m-1:0]        o_argA,
    output logic [m-1:0]        o_argB,
    output logic [3:0]          o_unit_sel,
    input  logic [m-1:0]        i_res0,
    input  logic [m-1:0]        i_res1,
    input  logic [m-1:0]        i_res2,
    input  logic [m-1:0]        i_res3,
    input  logic [1:0]          i_st0,
    input  logic [1:0]          i_st1,
    input  logic [1:0]          i_st2,
    input  logic [1:0]          i_st3,
    output logic                o_busy,
    output logic [7:0]          o_ops_done
);

    localparam int CW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [m-1:0]  r_argA;
    logic [m-1:0]  r_argB;
    logic [3:0]    r_sel;
    logic [m-1:0]  r_result;
    logic [1:0]    r_status;
    logic          r_valid;
    logic [7:0]    r_ops;

    logic          w_accept;
    logic          w_capture;
    logic          w_release;
    logic          w_op_hi;
    logic          w_op_sm;
    logic [3:0]    w_sel;
    logic [m-1:0]  w_cap_res;
    logic [1:0]    w_cap_st;

    // Opcodes above 3 only exist when the opcode is wider than two bits.
    if (n > 2) begin : g_op_hi
        assign w_op_hi = |io_bus.op[n-1:2];
    end else begin : g_no_op_hi
        assign w_op_hi = 1'b0;
    end

    assign w_op_sm = !w_op_hi && (io_bus.op[1:0] == 2'd3);
    assign w_sel   = w_op_hi ? 4'b0000 : (4'b0001 << io_bus.op[1:0]);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (io_bus.req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == CW'(1)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (io_bus.ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // An empty select (invalid op) captures result 0 with status 2'b11.
    always_comb begin
        w_cap_res = '0;
        w_cap_st  = 2'b11;
        unique case (1'b1)
            r_sel[0]: begin w_cap_res = i_res0; w_cap_st = i_st0; end
            r_sel[1]: begin w_cap_res = i_res1; w_cap_st = i_st1; end
            r_sel[2]: begin w_cap_res = i_res2; w_cap_st = i_st2; end
            r_sel[3]: begin w_cap_res = i_res3; w_cap_st = i_st3; end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_argA   <= '0;
            r_argB   <= '0;
            r_sel    <= '0;
            r_result <= '0;
            r_status <= '0;
            r_valid  <= 1'b0;
            r_ops    <= '0;
        end else begin
            if (w_accept) begin
                r_argA <= io_bus.argA;
                r_argB <= w_op_sm ? '0 : io_bus.argB;
                r_sel  <= w_sel;
                r_cnt  <= CW'(SETTLE);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_capture) begin
                r_result <= w_cap_res;
                r_status <= w_cap_st;
                r_valid  <= 1'b1;
            end
            if (w_release) begin
                r_valid <= 1'b0;
                r_sel   <= '0;
                if (r_ops != 8'hFF) begin
                    r_ops <= r_ops + 8'd1;
                end
            end
        end
    end

    assign io_bus.req_ready = (r_state == S_IDLE);
    assign io_bus.result    = r_result;
    assign io_bus.status    = r_status;
    assign io_bus.valid     = r_valid;
    assign o_argA           = r_argA;
    assign o_argB           = r_argB;
    assign o_unit_sel       = r_sel;
    assign o_busy           = (r_state != S_IDLE);
    assign o_ops_done       = r_ops;

endmodule
